// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the sequential bitwise logic unit:
//   - op codes (AND / OR / XOR / NOR)
//   - FSM state encoding (IDLE / RUN / DONE)
//   - clog2_min1: ceil(log2(n)), never less than 1, used to size the slice counter
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/logic_unit_seq_slice_logic.sv
// slice_logic
//   Combinational per-bit gate array for one SLICE-bit chunk.
//   Ports:
//     op  - operation select (see logic_unit_pkg op codes)
//     a,b - operand slices
//     y   - result slice
module slice_logic
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq
//   Multi-cycle bitwise logic unit. Operands are captured on accept and
//   processed SLICE bits per cycle, LSB slice first; the result and a zero
//   flag are presented once the last slice has been written.
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high. in_ready is high only in IDLE, out_valid only in
//   DONE; out_valid stays high with result/zero stable until out_ready.
//
//   Ports:
//     clock, reset        - rising-edge clock, async active-high reset
//     in_valid / in_ready - operand handshake (op, data_a, data_b)
//     out_valid/out_ready - result handshake (result, zero)
//     busy                - high in RUN or DONE
//     state_dbg           - current FSM state, for observation only
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = clog2_min1(NSLICE);

  // Operands and result are kept as arrays of slices so the counter
  // indexes the active chunk directly.
  typedef logic [NSLICE-1:0][SLICE-1:0] sliced_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  sliced_t         a_q;
  sliced_t         b_q;
  sliced_t         res_q;
  logic [1:0]      op_q;
  logic            zacc;
  logic            zero_q;
  logic [SLICE-1:0] y;
  logic            last;

  slice_logic #(.SLICE(SLICE)) u_slice (
    .op (op_q),
    .a  (a_q[cnt]),
    .b  (b_q[cnt]),
    .y  (y)
  );

  assign last = (cnt == CW'(NSLICE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      res_q  <= '0;
      zacc   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= data_a;
            b_q   <= data_b;
            op_q  <= op;
            res_q <= '0;
            zacc  <= 1'b0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[cnt] <= y;
          zacc       <= zacc | (|y);
          if (last) begin
            // Fold in the final slice here; zacc alone lags by one slice.
            zero_q <= ~(zacc | (|y));
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign state_dbg = state;

endmodule
